max_reduce_ctrl: RTL

Sequential max-reduction reader for the softmax datapath. On `start` it reads `num_words` consecutive 4-lane FP16 words from the score buffer, tracks a running maximum across all lanes and words, and presents the final maximum with a done pulse. The downstream subtract/exponent stage uses this value. The block owns the read side of the buffer interface: address generation, read-latency tracking and the accumulator register.

---
 rtl/max_reduce_ctrl_pkg.sv | 32 +++
 rtl/max_reduce_ctrl_if.sv | 46 ++++
 rtl/max_reduce_ctrl_max5_tree.sv | 27 ++
 rtl/max_reduce_ctrl.sv | 127 ++++++++++++
 4 files changed

// File: rtl/max_reduce_ctrl_pkg.sv
// Shared types, FP16 constants and the FP16 ordering helper used by the max-reduction reader.
// Replaces the defines.v constants so every file sees one definition.
package max_reduce_ctrl_pkg;

    localparam int unsigned DATAWIDTH       = 16;
    localparam int unsigned MANTISSA        = 10;
    localparam int unsigned EXPONENT        = 5;
    localparam int unsigned IEEE_COMPLIANCE = 0;
    localparam int unsigned LANES           = 4;

    localparam logic [DATAWIDTH-1:0] FP_NEG_INF = 16'hFC00;

    typedef logic [DATAWIDTH-1:0] fp16_t;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StDrain,
        StDone
    } state_e;

    // Maps FP16 onto an unsigned key with the same ordering (NaN excluded).
    function automatic logic [DATAWIDTH-1:0] fp_key(input fp16_t v);
        return v[DATAWIDTH-1] ? ~v : (v | {1'b1, {(DATAWIDTH-1){1'b0}}});
    endfunction

    // Equivalent of the z1 (max) output of a floating-point compare with zctr=0.
    function automatic fp16_t fp_max(input fp16_t a, input fp16_t b);
        return (fp_key(b) > fp_key(a)) ? b : a;
    endfunction

endpackage

// File: rtl/max_reduce_ctrl_if.sv
// Start/result handshake and buffer read port of the max-reduction reader.
// The slave modport is the reader itself; master is the surrounding datapath.
interface max_reduce_ctrl_if
    import max_reduce_ctrl_pkg::*;
#(
    parameter int unsigned ADDRW = 10
);

    logic                         start;
    logic [ADDRW-1:0]             base_addr;
    logic [ADDRW-1:0]             num_words;
    logic                         rd_en;
    logic [ADDRW-1:0]             rd_addr;
    logic [LANES*DATAWIDTH-1:0]   rd_data;
    logic                         busy;
    logic                         done;
    logic [DATAWIDTH-1:0]         max_out;
    logic                         max_valid;

    modport master (
        output start,
        output base_addr,
        output num_words,
        output rd_data,
        input  rd_en,
        input  rd_addr,
        input  busy,
        input  done,
        input  max_out,
        input  max_valid
    );

    modport slave (
        input  start,
        input  base_addr,
        input  num_words,
        input  rd_data,
        output rd_en,
        output rd_addr,
        output busy,
        output done,
        output max_out,
        output max_valid
    );

endinterface

// File: rtl/max_reduce_ctrl_max5_tree.sv
// Five-input FP16 maximum: lanes pairwise, then the pair winners, then against the accumulator.
// Purely combinational; three comparator levels deep.
module max5_tree
    import max_reduce_ctrl_pkg::*;
(
    input  logic [LANES*DATAWIDTH-1:0] lanes,
    input  fp16_t                      acc,
    output fp16_t                      max_out
);

    fp16_t lane [LANES];
    fp16_t max01;
    fp16_t max23;
    fp16_t max_lanes;

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            lane[i] = lanes[i*DATAWIDTH +: DATAWIDTH];
        end
    end

    assign max01     = fp_max(lane[0], lane[1]);
    assign max23     = fp_max(lane[2], lane[3]);
    assign max_lanes = fp_max(max01, max23);
    assign max_out   = fp_max(max_lanes, acc);

endmodule

// File: rtl/max_reduce_ctrl.sv
// Sequential max-reduction reader: streams num_words 4-lane FP16 words out of the score buffer
// and reports the running maximum with a one-cycle done pulse.
module max_reduce_ctrl
    import max_reduce_ctrl_pkg::*;
#(
    parameter int unsigned          ADDRW   = 10,
    parameter int unsigned          RD_LAT  = 1,
    parameter logic [DATAWIDTH-1:0] NEG_INF = FP_NEG_INF
) (
    input logic              clk,
    input logic              resetn,
    max_reduce_ctrl_if.slave bus
);

    state_e                     state_q, state_d;
    logic [ADDRW-1:0]           addr_q, addr_d;
    logic [ADDRW-1:0]           cnt_q, cnt_d;
    logic [RD_LAT-1:0]          vld_q, vld_d;
    logic                       cap_valid_q, cap_valid_d;
    logic [LANES*DATAWIDTH-1:0] cap_q, cap_d;
    fp16_t                      acc_q, acc_d;
    fp16_t                      max_q, max_d;
    logic                       max_valid_q, max_valid_d;
    fp16_t                      tree_max;
    logic                       rd_en;

    assign rd_en = (state_q == StIssue);

    max5_tree u_max5_tree (
        .lanes   (cap_q),
        .acc     (acc_q),
        .max_out (tree_max)
    );

    // Read-latency tracking: the tail of the valid shift register marks rd_data as live.
    always_comb begin
        vld_d    = '0;
        vld_d[0] = rd_en;
        for (int i = 1; i < RD_LAT; i++) begin
            vld_d[i] = vld_q[i-1];
        end
        cap_valid_d = vld_q[RD_LAT-1];
        cap_d       = cap_valid_d ? bus.rd_data : cap_q;
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        max_d       = max_q;
        max_valid_d = max_valid_q;

        if (cap_valid_q) begin
            acc_d = tree_max;
        end

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    addr_d      = bus.base_addr;
                    cnt_d       = bus.num_words;
                    acc_d       = NEG_INF;
                    max_valid_d = 1'b0;
                    state_d     = (bus.num_words != '0) ? StIssue : StDone;
                end
            end
            StIssue: begin
                addr_d = addr_q + ADDRW'(1);
                cnt_d  = cnt_q - ADDRW'(1);
                if (cnt_q == ADDRW'(1)) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                // Nothing left to capture; the last accumulate lands on this same edge.
                if (~|vld_q) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Result is registered on entry to DONE so it is visible alongside the done pulse.
        if (state_d == StDone && state_q != StDone) begin
            max_d       = acc_d;
            max_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            cnt_q       <= '0;
            vld_q       <= '0;
            cap_valid_q <= 1'b0;
            cap_q       <= '0;
            acc_q       <= NEG_INF;
            max_q       <= '0;
            max_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            vld_q       <= vld_d;
            cap_valid_q <= cap_valid_d;
            cap_q       <= cap_d;
            acc_q       <= acc_d;
            max_q       <= max_d;
            max_valid_q <= max_valid_d;
        end
    end

    assign bus.rd_en     = rd_en;
    assign bus.rd_addr   = addr_q;
    assign bus.busy      = (state_q != StIdle);
    assign bus.done      = (state_q == StDone);
    assign bus.max_out   = max_q;
    assign bus.max_valid = max_valid_q;

endmodule
